character_move_controller: RTL and testbench

- Sequencer directly upstream of the character drawer.
- Turns left/right key presses into position changes (POS0..POS3) on frame ticks.
- For each move, erases the character at the old position, then redraws it at the new one.
- Drives the drawer's position select and its restart (active-low reset) input, consumes its DoneDrawing, and gates VGA writeEn and the erase/draw colour select.

---
 rtl/character_move_controller_pkg.sv | 29 ++
 rtl/character_move_controller_key_edge_sync.sv | 28 ++
 rtl/character_move_controller.sv | 156 +++++++++++++++
 tb/tb_character_move_controller.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/character_move_controller_pkg.sv
// rtl/character_move_controller_pkg.sv - shared encodings for the character move sequencer and drawer
package character_move_controller_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ERASE_START = 3'd1,
    ERASE_RUN   = 3'd2,
    MOVE        = 3'd3,
    DRAW_START  = 3'd4,
    DRAW_RUN    = 3'd5
  } state_t;

  localparam logic [1:0] POS0 = 2'd0;
  localparam logic [1:0] POS1 = 2'd1;
  localparam logic [1:0] POS2 = 2'd2;
  localparam logic [1:0] POS3 = 2'd3;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } pending_t;

  // Positions clamp at the screen edges; there is no wrap-around.
  function automatic logic move_legal(input pending_t dir, input logic [1:0] pos);
    return ((dir == LEFT) && (pos != POS0)) || ((dir == RIGHT) && (pos != POS3));
  endfunction

endpackage

// File: rtl/character_move_controller_key_edge_sync.sv
// rtl/character_move_controller_key_edge_sync.sv - key synchronizer with falling-edge press pulse
module key_edge_sync (
  input  logic Clock,
  input  logic Reset,
  input  logic key,
  output logic press
);

  logic sync1;
  logic sync2;
  logic prev;

  // Buttons idle high, so all stages reset to the released level.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign press = prev & ~sync2;

endmodule

// File: rtl/character_move_controller.sv
// rtl/character_move_controller.sv - erase/move/redraw sequencer driving the character drawer
module character_move_controller
  import character_move_controller_pkg::*;
#(
  parameter int HOLD_FRAMES  = 4,
  parameter int START_CYCLES = 2,
  parameter int WATCHDOG     = 128
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       KeyLeft,
  input  logic       KeyRight,
  input  logic       FrameTick,
  input  logic       DoneDrawing,
  output logic [3:0] DrawPos,
  output logic       DrawerReset,
  output logic       Erase,
  output logic       PlotEn,
  output logic       Busy,
  output logic       Fault
);

  localparam int HW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam int SW = $clog2(START_CYCLES + 1);
  localparam int WW = $clog2(WATCHDOG + 1);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_FRAMES);
  localparam logic [SW-1:0] START_LAST = SW'(START_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST    = WW'(WATCHDOG - 1);

  state_t          state;
  state_t          state_n;
  pending_t        pending;
  logic [1:0]      pos;
  logic            dir_right;
  logic [HW-1:0]   hold;
  logic [SW-1:0]   start_cnt;
  logic [WW-1:0]   wd_cnt;
  logic            fault;
  logic            press_left;
  logic            press_right;
  logic            accept;
  logic            reject;
  logic            timeout;

  key_edge_sync u_left (
    .Clock (Clock),
    .Reset (Reset),
    .key   (KeyLeft),
    .press (press_left)
  );

  key_edge_sync u_right (
    .Clock (Clock),
    .Reset (Reset),
    .key   (KeyRight),
    .press (press_right)
  );

  always_comb begin
    state_n     = state;
    DrawerReset = 1'b1;
    Erase       = 1'b0;
    PlotEn      = 1'b0;
    accept      = 1'b0;
    reject      = 1'b0;
    timeout     = 1'b0;
    case (state)
      IDLE: begin
        if (FrameTick && (pending != NONE) && (hold == '0)) begin
          if (move_legal(pending, pos)) begin
            accept  = 1'b1;
            state_n = ERASE_START;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ERASE_START: begin
        DrawerReset = 1'b0;
        Erase       = 1'b1;
        if (start_cnt == START_LAST) state_n = ERASE_RUN;
      end
      ERASE_RUN: begin
        Erase   = 1'b1;
        PlotEn  = 1'b1;
        timeout = (wd_cnt == WD_LAST);
        if (DoneDrawing || timeout) state_n = MOVE;
      end
      MOVE: begin
        state_n = DRAW_START;
      end
      DRAW_START: begin
        DrawerReset = 1'b0;
        if (start_cnt == START_LAST) state_n = DRAW_RUN;
      end
      DRAW_RUN: begin
        PlotEn  = 1'b1;
        timeout = (wd_cnt == WD_LAST);
        if (DoneDrawing || timeout) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state     <= DRAW_START;
      pos       <= POS0;
      dir_right <= 1'b0;
      pending   <= NONE;
      hold      <= '0;
      start_cnt <= '0;
      wd_cnt    <= '0;
      fault     <= 1'b0;
    end else begin
      state <= state_n;

      // Both counters restart whenever the state changes, so each pass starts from zero.
      if (((state == ERASE_START) || (state == DRAW_START)) && (state_n == state))
        start_cnt <= start_cnt + SW'(1);
      else
        start_cnt <= '0;

      if (((state == ERASE_RUN) || (state == DRAW_RUN)) && (state_n == state))
        wd_cnt <= wd_cnt + WW'(1);
      else
        wd_cnt <= '0;

      if (timeout && !DoneDrawing) fault <= 1'b1;

      if (accept) dir_right <= (pending == RIGHT);

      if (state == MOVE) pos <= dir_right ? (pos + 2'd1) : (pos - 2'd1);

      if (accept)
        hold <= HOLD_LOAD;
      else if (FrameTick && (hold != '0))
        hold <= hold - HW'(1);

      // A fresh press wins over the accept/reject clear so it is not lost.
      if (press_left && press_right)
        pending <= NONE;
      else if (press_left)
        pending <= LEFT;
      else if (press_right)
        pending <= RIGHT;
      else if (accept || reject)
        pending <= NONE;
    end
  end

  assign DrawPos = {2'b00, pos};
  assign Busy    = (state != IDLE);
  assign Fault   = fault;

endmodule

// File: tb/tb_character_move_controller.sv
// tb/tb_character_move_controller.sv - randomized self-checking bench for character_move_controller
module tb_character_move_controller;

  localparam int HOLD = 4;
  localparam int WD   = 128;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       KeyLeft = 1'b1;
  logic       KeyRight = 1'b1;
  logic       FrameTick = 1'b0;
  logic       DoneDrawing = 1'b0;
  logic [3:0] DrawPos;
  logic       DrawerReset;
  logic       Erase;
  logic       PlotEn;
  logic       Busy;
  logic       Fault;

  int vectors = 0;
  int miscompares = 0;

  int m_pos = 0;
  int m_pend = 0;
  int m_hold = 0;
  int m_fault = 0;

  int   draw_len = 8;
  int   dcnt = 0;
  logic no_done = 1'b0;

  logic [2:0] plog[$];
  logic       plot_q = 1'b0;
  logic [2:0] cur = 3'd0;
  int         unstable_cnt = 0;
  int         busy_cnt = 0;

  character_move_controller #(
    .HOLD_FRAMES  (HOLD),
    .START_CYCLES (2),
    .WATCHDOG     (WD)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .KeyLeft     (KeyLeft),
    .KeyRight    (KeyRight),
    .FrameTick   (FrameTick),
    .DoneDrawing (DoneDrawing),
    .DrawPos     (DrawPos),
    .DrawerReset (DrawerReset),
    .Erase       (Erase),
    .PlotEn      (PlotEn),
    .Busy        (Busy),
    .Fault       (Fault)
  );

  always #5 Clock = ~Clock;

  // Drawer stand-in: done becomes a level draw_len cycles after its restart is released.
  always @(posedge Clock) begin
    if (!DrawerReset) begin
      dcnt        <= 0;
      DoneDrawing <= 1'b0;
    end else begin
      if (dcnt < draw_len) dcnt <= dcnt + 1;
      DoneDrawing <= !no_done && (dcnt >= draw_len);
    end
  end

  // Logs {Erase, pos} at the start of every plotting pass and flags any change mid-pass.
  always @(negedge Clock) begin
    plot_q <= PlotEn;
    if (Busy) busy_cnt <= busy_cnt + 1;
    if (PlotEn && !plot_q) begin
      plog.push_back({Erase, DrawPos[1:0]});
      cur <= {Erase, DrawPos[1:0]};
    end else if (PlotEn && (({Erase, DrawPos[1:0]} != cur) || (DrawPos[3:2] != 2'b00))) begin
      unstable_cnt <= unstable_cnt + 1;
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (Busy && n < 1000) begin
      @(negedge Clock);
      n++;
    end
    vectors++;
    if (Busy) begin
      miscompares++;
      $display("FAIL idle_timeout: Busy=%0d after %0d cycles, required 0", Busy, n);
    end
  endtask

  task automatic press(input int code);
    @(negedge Clock);
    if (code == 1 || code == 3) KeyLeft = 1'b0;
    if (code == 2 || code == 3) KeyRight = 1'b0;
    repeat (4) @(negedge Clock);
    KeyLeft  = 1'b1;
    KeyRight = 1'b1;
    repeat (4) @(negedge Clock);
    m_pend = (code == 3) ? 0 : code;
  endtask

  task automatic do_step(input int code, output logic moved);
    int   old_pos;
    logic exp_move;
    int   u0;
    int   b0;
    if (code != 0) press(code);
    old_pos  = m_pos;
    exp_move = 1'b0;
    if (m_hold == 0 && m_pend != 0) begin
      if ((m_pend == 1 && m_pos > 0) || (m_pend == 2 && m_pos < 3)) begin
        exp_move = 1'b1;
        m_pos    = (m_pend == 2) ? m_pos + 1 : m_pos - 1;
        m_hold   = HOLD;
      end
      m_pend = 0;
    end else if (m_hold > 0) begin
      m_hold--;
    end
    plog.delete();
    @(negedge Clock);
    u0 = unstable_cnt;
    b0 = busy_cnt;
    FrameTick = 1'b1;
    @(negedge Clock);
    FrameTick = 1'b0;
    repeat (2) @(negedge Clock);
    wait_idle();
    moved = (plog.size() != 0);
    vectors++;
    if (plog.size() != (exp_move ? 2 : 0)) begin
      miscompares++;
      $display("FAIL pass_count: got %0d passes, required %0d (pos %0d key %0d)",
               plog.size(), exp_move ? 2 : 0, old_pos, code);
    end else if (exp_move) begin
      vectors++;
      if (plog[0] !== {1'b1, 2'(old_pos)} || plog[1] !== {1'b0, 2'(m_pos)}) begin
        miscompares++;
        $display("FAIL pass_order: got %b,%b required %b,%b", plog[0], plog[1],
                 {1'b1, 2'(old_pos)}, {1'b0, 2'(m_pos)});
      end
    end else begin
      vectors++;
      if (busy_cnt != b0) begin
        miscompares++;
        $display("FAIL idle_busy: got %0d busy cycles, required 0", busy_cnt - b0);
      end
    end
    vectors++;
    if (DrawPos !== 4'(m_pos) || Fault !== 1'(m_fault) || unstable_cnt != u0) begin
      miscompares++;
      $display("FAIL step_state: DrawPos=%0d Fault=%0d unstable=%0d, required %0d %0d 0",
               DrawPos, Fault, unstable_cnt - u0, m_pos, m_fault);
    end
  endtask

  task automatic flush();
    logic mv;
    while (m_hold > 0) do_step(0, mv);
  endtask

  task automatic test_reset();
    int n;
    int k;
    Reset = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    vectors++;
    if (DrawPos !== 4'd0 || DrawerReset !== 1'b0 || Erase !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_draw: DrawPos=%0d DrawerReset=%0d Erase=%0d, required 0 0 0",
               DrawPos, DrawerReset, Erase);
    end
    vectors++;
    if (PlotEn !== 1'b0 || Busy !== 1'b1 || Fault !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: PlotEn=%0d Busy=%0d Fault=%0d, required 0 1 0",
               PlotEn, Busy, Fault);
    end
    Reset = 1'b1;
    n = 0;
    k = 0;
    while (!PlotEn && k < 20) begin
      if (!DrawerReset && !Erase && DrawPos == 4'd0) n++;
      @(negedge Clock);
      k++;
    end
    vectors++;
    if (n != 2 || !PlotEn) begin
      miscompares++;
      $display("FAIL reset_start_len: got %0d start cycles PlotEn=%0d, required 2 1", n, PlotEn);
    end
    wait_idle();
    vectors++;
    if (DrawPos !== 4'd0 || Fault !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: DrawPos=%0d Fault=%0d, required 0 0", DrawPos, Fault);
    end
    m_pos = 0; m_pend = 0; m_hold = 0; m_fault = 0;
  endtask

  task automatic test_latency();
    int k;
    press(2);
    plog.delete();
    @(negedge Clock);
    FrameTick = 1'b1;
    @(negedge Clock);
    FrameTick = 1'b0;
    k = 1;
    while (!PlotEn && k < 20) begin
      @(negedge Clock);
      k++;
    end
    vectors++;
    if (k != 3 || Erase !== 1'b1 || DrawPos !== 4'd0) begin
      miscompares++;
      $display("FAIL latency: first PlotEn after %0d cycles Erase=%0d DrawPos=%0d, required 3 1 0",
               k, Erase, DrawPos);
    end
    wait_idle();
    vectors++;
    if (plog.size() != 2 || DrawPos !== 4'd1) begin
      miscompares++;
      $display("FAIL latency_passes: got %0d passes DrawPos=%0d, required 2 1", plog.size(), DrawPos);
    end else begin
      vectors++;
      if (plog[0] !== 3'b100 || plog[1] !== 3'b001) begin
        miscompares++;
        $display("FAIL latency_order: got %b,%b required 100,001", plog[0], plog[1]);
      end
    end
    m_pos = 1; m_pend = 0; m_hold = HOLD;
  endtask

  task automatic test_rate_limit();
    logic mv;
    int   t;
    flush();
    do_step(2, mv);
    press(2);
    t = 0;
    mv = 1'b0;
    while (!mv && t < 8) begin
      do_step(0, mv);
      t++;
    end
    vectors++;
    if (t != 5 || !mv) begin
      miscompares++;
      $display("FAIL rate_limit: second move on tick %0d moved=%0d, required 5 1", t, mv);
    end
  endtask

  task automatic test_clamp();
    logic mv;
    flush();
    do_step(2, mv);
    vectors++;
    if (mv !== 1'b0) begin
      miscompares++;
      $display("FAIL clamp_right: moved=%0d at pos 3, required 0", mv);
    end
    repeat (3) begin
      flush();
      do_step(1, mv);
    end
    flush();
    do_step(1, mv);
    vectors++;
    if (mv !== 1'b0 || m_pend != 0) begin
      miscompares++;
      $display("FAIL clamp_left: moved=%0d at pos 0, required 0", mv);
    end
  endtask

  task automatic test_keys();
    logic mv;
    flush();
    do_step(3, mv);
    vectors++;
    if (mv !== 1'b0) begin
      miscompares++;
      $display("FAIL both_keys: moved=%0d, required 0", mv);
    end
    press(1);
    do_step(2, mv);
    vectors++;
    if (mv !== 1'b1 || DrawPos !== 4'd1) begin
      miscompares++;
      $display("FAIL overwrite: moved=%0d DrawPos=%0d, required 1 1", mv, DrawPos);
    end
  endtask

  task automatic test_watchdog();
    int n;
    flush();
    no_done = 1'b1;
    press(2);
    plog.delete();
    @(negedge Clock);
    FrameTick = 1'b1;
    @(negedge Clock);
    FrameTick = 1'b0;
    n = 0;
    while (!PlotEn && n < 20) begin
      @(negedge Clock);
      n++;
    end
    n = 0;
    while (PlotEn && n < 400) begin
      @(negedge Clock);
      n++;
    end
    vectors++;
    if (n != WD) begin
      miscompares++;
      $display("FAIL watchdog_len: RUN lasted %0d cycles, required %0d", n, WD);
    end
    vectors++;
    if (Fault !== 1'b1 || Busy !== 1'b1 || DrawPos !== 4'd1) begin
      miscompares++;
      $display("FAIL watchdog_exit: Fault=%0d Busy=%0d DrawPos=%0d, required 1 1 1",
               Fault, Busy, DrawPos);
    end
    no_done = 1'b0;
    wait_idle();
    vectors++;
    if (DrawPos !== 4'd2 || Fault !== 1'b1) begin
      miscompares++;
      $display("FAIL watchdog_after: DrawPos=%0d Fault=%0d, required 2 1", DrawPos, Fault);
    end
    m_pos = 2; m_pend = 0; m_hold = HOLD; m_fault = 1;
    flush();
  endtask

  task automatic test_reset_mid_pass();
    int n;
    press(1);
    @(negedge Clock);
    FrameTick = 1'b1;
    @(negedge Clock);
    FrameTick = 1'b0;
    n = 0;
    while (!(PlotEn && !Erase) && n < 200) begin
      @(negedge Clock);
      n++;
    end
    Reset = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    vectors++;
    if (DrawPos !== 4'd0 || DrawerReset !== 1'b0 || Erase !== 1'b0 || Fault !== 1'b0 ||
        Busy !== 1'b1 || PlotEn !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: DrawPos=%0d DrawerReset=%0d Erase=%0d Fault=%0d Busy=%0d PlotEn=%0d, required 0 0 0 0 1 0",
               DrawPos, DrawerReset, Erase, Fault, Busy, PlotEn);
    end
    wait_idle();
    m_pos = 0; m_pend = 0; m_hold = 0; m_fault = 0;
  endtask

  task automatic test_random();
    logic mv;
    int   c;
    for (int i = 0; i < 40; i++) begin
      draw_len = $urandom_range(2, 20);
      if ($urandom_range(0, 3) == 0) press($urandom_range(1, 2));
      c = $urandom_range(0, 5);
      do_step((c > 3) ? 0 : c, mv);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_rate_limit();
    test_clamp();
    test_keys();
    test_watchdog();
    test_reset_mid_pass();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
